div_share_arbiter: RTL and testbench
====================================

Name: div_share_arbiter

Overview:
Shares one iterative restoring divider (`divider`, WIDTH-bit, start/ready handshake) among NREQ requesters in the AR pipeline, such as the perspective-divide and centroid units.
- Arbitrates requests round-robin and latches the winner's operands.
- Issues a single-cycle start to the divider and waits for its done pulse.
- Returns quotient/remainder to the winner on a valid/ready response channel.
- Short-circuits divide-by-zero without using the divider, and recovers from a missing done pulse with a watchdog.

Parameters:
- WIDTH, 8, operand/result width; must match the attached divider.
- NREQ, 4, number of requesters, 2..8.
- IDW, 2, requester id width, clog2(NREQ), minimum 1.
- TIMEOUT, WIDTH+8, maximum WAIT cycles before abort.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester request accept, one-hot or zero.
- req_sign  in  NREQ  per-requester signed (1) / unsigned (0) flag.
- req_dividend  in  NREQ*WIDTH  packed dividends; requester i at [i*WIDTH +: WIDTH].
- req_divisor  in  NREQ*WIDTH  packed divisors, same packing.
- rsp_valid  out  NREQ  one-hot response valid.
- rsp_ready  in  NREQ  per-requester response accept.
- rsp_quotient  out  WIDTH  result quotient.
- rsp_remainder  out  WIDTH  result remainder.
- rsp_err  out  2  result status: 00 ok, 01 divide-by-zero, 10 timeout.
- rsp_id  out  IDW  id of the responding requester.
- div_start  out  1  start pulse to the divider.
- div_sign  out  1  sign flag to the divider.
- div_dividend  out  WIDTH  dividend to the divider.
- div_divisor  out  WIDTH  divisor to the divider.
- div_ready  in  1  divider done pulse.
- div_quotient  in  WIDTH  divider quotient.
- div_remainder  in  WIDTH  divider remainder.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE; rr_last = NREQ-1, so requester 0 wins first.
  - Outputs zero: req_ready, rsp_valid, div_start, div_sign, div_dividend, div_divisor, rsp_quotient, rsp_remainder, rsp_err, rsp_id.
  - Reset mid-operation abandons the transaction; a later div_ready pulse is ignored.
- IDLE:
  - Grant = first asserted req_valid searching from rr_last+1, wrapping modulo NREQ.
  - req_ready = grant, combinational, asserted only in IDLE.
  - On handshake, register id, sign and operands, set rr_last = id.
  - If divisor == 0, go to RESP with quotient all-ones, remainder = dividend, err=01; div_start is never pulsed.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle):
  - div_start=1 with div_sign/div_dividend/div_divisor driven from the registers.
  - Operand outputs hold until the transaction ends.
  - Clear the watchdog; go to WAIT.
  - div_ready in this cycle is stale and ignored.
- WAIT:
  - Watchdog increments each cycle.
  - On div_ready=1: capture div_quotient/div_remainder, err=00, go to RESP.
  - If the watchdog reaches TIMEOUT first: quotient=0, remainder=0, err=10, go to RESP.
  - div_ready and timeout in the same cycle: div_ready wins.
- RESP:
  - rsp_valid[id]=1; rsp_quotient/rsp_remainder/rsp_err/rsp_id held stable.
  - On rsp_ready[id], go to IDLE the next cycle.
  - rsp_ready of other requesters is ignored.
  - No new grant until the response completes, so one transaction is in flight.
- Latency, with the team divider (div_ready high WIDTH cycles after the div_start cycle):
  - Accept at cycle T, start at T+1, div_ready at T+1+WIDTH, rsp_valid at T+2+WIDTH.
  - Divide-by-zero: rsp_valid at T+1.
- Fairness: a continuously requesting requester waits at most NREQ-1 transactions.
- Requester rules: req_valid may drop before its grant without penalty. Operands need only be valid in the handshake cycle.
- Width rules: sign is passed through; the block performs no arithmetic besides the zero compare and the watchdog.

Decomposition:
- Shared package div_share_pkg:
  - state enum {IDLE, ISSUE, WAIT, RESP};
  - rsp_err codes ERR_OK=2'b00, ERR_DBZ=2'b01, ERR_TMO=2'b10.
- One natural sub-module: rr_arbiter (NREQ-wide round-robin grant from req vector and last pointer, combinational, plus pointer-update enable).
- The divider is instantiated by the parent, not inside this block.

Test Plan:
1. Reset, then req_valid[1]=1, 100/7 unsigned (WIDTH=8, divider model) -> req_ready[1] at cycle 0, div_start cycle 1, rsp_valid[1] cycle 10, q=14, r=2, err=00, id=1.
2. All four requesters valid continuously, rsp_ready tied high -> grant order 0,1,2,3,0; no requester is granted twice before the others are served.
3. Divisor 0, dividend 0x55, requester 2 -> div_start never asserts; rsp_valid[2] next cycle, q=0xFF, r=0x55, err=01.
4. Divider model never pulses div_ready -> after TIMEOUT WAIT cycles rsp_valid, q=0, r=0, err=10; the next request is served normally.
5. rsp_ready held low 20 cycles while others request -> rsp outputs stable; req_ready stays zero; a grant follows only after the rsp_ready handshake.
6. rst_n low during WAIT, with a spurious div_ready right after release -> all outputs zero; state IDLE; no rsp_valid produced; requester 0 has priority.

Source files
------------

// File: rtl/div_share_pkg.sv
// Shared types for the divider-sharing arbiter.
// FSM states and response status codes.
package div_share_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_DBZ = 2'b01;
  localparam logic [1:0] ERR_TMO = 2'b10;

endpackage

// File: rtl/div_share_arbiter_rr.sv
// Round-robin grant over NREQ requests.
// The last-winner pointer advances only when upd is set.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            upd,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            any
);

  logic [IDW-1:0] last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= IDW'(NREQ - 1);
    end else if (upd) begin
      last <= grant_id;
    end
  end

  always_comb begin
    int idx;
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!any && req[idx]) begin
        any         = 1'b1;
        grant[idx]  = 1'b1;
        grant_id    = IDW'(idx);
      end
    end
  end

endmodule

// File: rtl/div_share_arbiter.sv
// Shares one iterative divider among NREQ requesters.
// One transaction in flight; divide-by-zero bypasses the divider.
module div_share_arbiter
  import div_share_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int TIMEOUT = WIDTH + 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ-1:0]       req_sign,
  input  logic [NREQ*WIDTH-1:0] req_dividend,
  input  logic [NREQ*WIDTH-1:0] req_divisor,
  output logic [NREQ-1:0]       rsp_valid,
  input  logic [NREQ-1:0]       rsp_ready,
  output logic [WIDTH-1:0]      rsp_quotient,
  output logic [WIDTH-1:0]      rsp_remainder,
  output logic [1:0]            rsp_err,
  output logic [IDW-1:0]        rsp_id,
  output logic                  div_start,
  output logic                  div_sign,
  output logic [WIDTH-1:0]      div_dividend,
  output logic [WIDTH-1:0]      div_divisor,
  input  logic                  div_ready,
  input  logic [WIDTH-1:0]      div_quotient,
  input  logic [WIDTH-1:0]      div_remainder
);

  localparam int WDW = $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

  state_t state_q, state_d;

  logic [NREQ-1:0]  grant;
  logic [IDW-1:0]   gnt_id;
  logic             gnt_any;
  logic             rr_upd;
  logic [WIDTH-1:0] sel_dvd;
  logic [WIDTH-1:0] sel_dvs;
  logic             sel_zero;

  logic [IDW-1:0]   id_q;
  logic             sign_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic [1:0]       err_q;
  logic [WDW-1:0]   wd_q;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req_valid),
    .upd      (rr_upd),
    .grant    (grant),
    .grant_id (gnt_id),
    .any      (gnt_any)
  );

  assign sel_dvd  = req_dividend[int'(gnt_id)*WIDTH +: WIDTH];
  assign sel_dvs  = req_divisor[int'(gnt_id)*WIDTH +: WIDTH];
  assign sel_zero = (sel_dvs == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    rsp_valid = '0;
    div_start = 1'b0;
    rr_upd    = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = grant;
        if (gnt_any) begin
          rr_upd  = 1'b1;
          state_d = sel_zero ? RESP : ISSUE;
        end
      end
      ISSUE: begin
        div_start = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (div_ready || wd_q == WD_LAST) state_d = RESP;
      end
      RESP: begin
        rsp_valid[id_q] = 1'b1;
        if (rsp_ready[id_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // div_ready wins over an expiring watchdog in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_q   <= '0;
      sign_q <= 1'b0;
      dvd_q  <= '0;
      dvs_q  <= '0;
      q_q    <= '0;
      r_q    <= '0;
      err_q  <= ERR_OK;
      wd_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_any) begin
            id_q   <= gnt_id;
            sign_q <= req_sign[gnt_id];
            dvd_q  <= sel_dvd;
            dvs_q  <= sel_dvs;
            if (sel_zero) begin
              q_q   <= '1;
              r_q   <= sel_dvd;
              err_q <= ERR_DBZ;
            end
          end
        end
        ISSUE: wd_q <= '0;
        WAIT: begin
          if (div_ready) begin
            q_q   <= div_quotient;
            r_q   <= div_remainder;
            err_q <= ERR_OK;
          end else if (wd_q == WD_LAST) begin
            q_q   <= '0;
            r_q   <= '0;
            err_q <= ERR_TMO;
          end else begin
            wd_q <= wd_q + WDW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign div_sign      = sign_q;
  assign div_dividend  = dvd_q;
  assign div_divisor   = dvs_q;
  assign rsp_quotient  = q_q;
  assign rsp_remainder = r_q;
  assign rsp_err       = err_q;
  assign rsp_id        = id_q;

endmodule

// File: tb/tb_div_share_arbiter.sv
// Randomized and directed bench for div_share_arbiter.
// A transaction-level scoreboard predicts grants, latency and results.
module tb_div_share_arbiter;

  localparam int W   = 8;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TMO = W + 8;

  logic           clk = 1'b0;
  logic           rst_n = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   req_sign = '0;
  logic [N*W-1:0] req_dividend = '0;
  logic [N*W-1:0] req_divisor = '0;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready = '0;
  logic [W-1:0]   rsp_quotient;
  logic [W-1:0]   rsp_remainder;
  logic [1:0]     rsp_err;
  logic [IDW-1:0] rsp_id;
  logic           div_start;
  logic           div_sign;
  logic [W-1:0]   div_dividend;
  logic [W-1:0]   div_divisor;
  logic           div_ready;
  logic [W-1:0]   div_quotient;
  logic [W-1:0]   div_remainder;

  int total = 0;
  int bad = 0;

  div_share_arbiter #(
    .WIDTH(W), .NREQ(N), .IDW(IDW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_sign(req_sign), .req_dividend(req_dividend),
    .req_divisor(req_divisor),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_quotient(rsp_quotient), .rsp_remainder(rsp_remainder),
    .rsp_err(rsp_err), .rsp_id(rsp_id),
    .div_start(div_start), .div_sign(div_sign),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_ready(div_ready), .div_quotient(div_quotient),
    .div_remainder(div_remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_div(input logic s,
      input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W-1:0] sa, sb;
    logic [W-1:0] q, r;
    sa = a;
    sb = b;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  function automatic logic [N-1:0] rr_pick(input logic [N-1:0] v,
                                           input int last);
    logic [N-1:0] g;
    int i;
    g = '0;
    for (int k = 1; k <= N; k++) begin
      i = (last + k) % N;
      if (v[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  // Behavioural divider: result WIDTH cycles after the start cycle
  logic         hang = 1'b0;
  logic         spur = 1'b0;
  logic         m_rdy;
  logic [W-1:0] m_q, m_r;
  int           m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rdy <= 1'b0;
      m_cnt <= 0;
      m_q   <= '0;
      m_r   <= '0;
    end else begin
      m_rdy <= 1'b0;
      if (div_start) begin
        m_cnt <= W - 1;
        {m_q, m_r} <= ref_div(div_sign, div_dividend, div_divisor);
      end else if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1 && !hang) m_rdy <= 1'b1;
      end
    end
  end

  assign div_ready     = m_rdy | spur;
  assign div_quotient  = m_q;
  assign div_remainder = m_r;

  // Scoreboard
  int           cyc = 0;
  logic         busy = 1'b0;
  int           rr_last = N - 1;
  int           gq[$];
  int           nstart = 0;
  int           t_id, t_hs, t_rsp;
  logic         t_dbz, t_seen;
  logic [W-1:0] t_q, t_r;
  logic [1:0]   t_err;
  int           lat;
  logic [W-1:0] lq, lr;
  logic [1:0]   lerr;
  int           lid;
  logic [N-1:0] eg, erv;
  logic         done;
  logic [W-1:0] a_op, b_op;

  always @(negedge clk) begin
    if (!rst_n) begin
      busy    = 1'b0;
      rr_last = N - 1;
      gq.delete();
      chk("rst_req_ready", 32'(req_ready), 0);
      chk("rst_rsp_valid", 32'(rsp_valid), 0);
      chk("rst_div_start", 32'(div_start), 0);
      chk("rst_div_sign", 32'(div_sign), 0);
      chk("rst_div_dvd", 32'(div_dividend), 0);
      chk("rst_div_dvs", 32'(div_divisor), 0);
      chk("rst_rsp_q", 32'(rsp_quotient), 0);
      chk("rst_rsp_r", 32'(rsp_remainder), 0);
      chk("rst_rsp_err", 32'(rsp_err), 0);
      chk("rst_rsp_id", 32'(rsp_id), 0);
    end else begin
      cyc++;
      done = 1'b0;
      if (div_start) nstart++;
      erv = '0;
      if (busy && cyc >= t_rsp) erv[t_id] = 1'b1;
      chk("rsp_valid", 32'(rsp_valid), 32'(erv));
      chk("div_start", 32'(div_start),
          32'(busy && !t_dbz && cyc == t_hs + 1));
      if (erv != '0) begin
        if (!t_seen) begin
          t_seen = 1'b1;
          lat = cyc - t_hs;
        end
        lq = rsp_quotient;
        lr = rsp_remainder;
        lerr = rsp_err;
        lid = int'(rsp_id);
        chk("rsp_q", 32'(rsp_quotient), 32'(t_q));
        chk("rsp_r", 32'(rsp_remainder), 32'(t_r));
        chk("rsp_err", 32'(rsp_err), 32'(t_err));
        chk("rsp_id", 32'(rsp_id), 32'(t_id));
        if (rsp_ready[t_id]) done = 1'b1;
      end
      eg = busy ? '0 : rr_pick(req_valid, rr_last);
      chk("req_ready", 32'(req_ready), 32'(eg));
      if (eg != '0) begin
        for (int i = 0; i < N; i++) if (eg[i]) t_id = i;
        a_op   = req_dividend[t_id*W +: W];
        b_op   = req_divisor[t_id*W +: W];
        t_hs   = cyc;
        t_seen = 1'b0;
        t_dbz  = (b_op == '0);
        if (t_dbz) begin
          t_q = '1; t_r = a_op; t_err = 2'b01; t_rsp = cyc + 1;
        end else if (hang) begin
          t_q = '0; t_r = '0; t_err = 2'b10; t_rsp = cyc + 2 + TMO;
        end else begin
          {t_q, t_r} = ref_div(req_sign[t_id], a_op, b_op);
          t_err = 2'b00; t_rsp = cyc + 2 + W;
        end
        rr_last = t_id;
        gq.push_back(t_id);
        busy = 1'b1;
      end
      if (done) busy = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(input logic want, input int budget,
                           input string tag);
    int n = 0;
    while (busy !== want && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(busy), 32'(want));
  endtask

  task automatic serve(input int id, input logic s,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    req_valid = '0;
    req_valid[id] = 1'b1;
    req_sign[id] = s;
    req_dividend[id*W +: W] = a;
    req_divisor[id*W +: W] = b;
    rsp_ready = '1;
    wait_busy(1'b1, 50, "serve_grant");
    req_valid = '0;
    wait_busy(1'b0, 200, "serve_done");
  endtask

  task automatic do_reset();
    req_valid = '0;
    rsp_ready = '0;
    spur = 1'b0;
    hang = 1'b0;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  int expo[5] = '{0, 1, 2, 3, 0};
  int n0;

  initial begin
    #2;
    do_reset();

    // 100/7 unsigned from requester 1
    serve(1, 1'b0, 8'd100, 8'd7);
    chk("t1_q", 32'(lq), 14);
    chk("t1_r", 32'(lr), 2);
    chk("t1_err", 32'(lerr), 0);
    chk("t1_id", lid, 1);
    chk("t1_lat", lat, 10);

    // all requesters continuously valid
    do_reset();
    for (int i = 0; i < N; i++) begin
      req_dividend[i*W +: W] = W'($urandom);
      req_divisor[i*W +: W] = W'($urandom_range(1, 255));
    end
    req_valid = '1;
    rsp_ready = '1;
    for (int n = 0; n < 200 && gq.size() < 5; n++) step();
    chk("t2_count", 32'(gq.size() >= 5), 1);
    for (int k = 0; k < 5; k++)
      chk("t2_order", (k < gq.size()) ? gq[k] : -1, expo[k]);
    req_valid = '0;
    wait_busy(1'b0, 200, "t2_drain");

    // divide by zero
    n0 = nstart;
    serve(2, 1'b0, 8'h55, 8'h00);
    chk("t3_q", 32'(lq), 32'hFF);
    chk("t3_r", 32'(lr), 32'h55);
    chk("t3_err", 32'(lerr), 1);
    chk("t3_id", lid, 2);
    chk("t3_lat", lat, 1);
    chk("t3_nostart", nstart - n0, 0);

    // missing done pulse, then a normal request
    hang = 1'b1;
    serve(0, 1'b0, 8'd9, 8'd3);
    chk("t4_err", 32'(lerr), 2);
    chk("t4_q", 32'(lq), 0);
    chk("t4_r", 32'(lr), 0);
    chk("t4_lat", lat, 2 + TMO);
    hang = 1'b0;
    serve(3, 1'b1, 8'hF9, 8'd2);
    chk("t4_after_err", 32'(lerr), 0);
    chk("t4_after_q", 32'(lq), 32'hFD);
    chk("t4_after_r", 32'(lr), 32'hFF);

    // response back-pressure while others keep requesting
    rsp_ready = '0;
    req_valid = '1;
    wait_busy(1'b1, 50, "t5_grant");
    n0 = gq.size();
    for (int n = 0; n < 30; n++) step();
    chk("t5_no_grant", gq.size(), n0);
    rsp_ready = '1;
    for (int n = 0; n < 3; n++) step();
    chk("t5_next_grant", gq.size(), n0 + 1);
    req_valid = '0;
    wait_busy(1'b0, 200, "t5_drain");

    // reset while waiting on the divider
    serve(2, 1'b0, 8'd50, 8'd5);
    req_valid[1] = 1'b1;
    req_divisor[1*W +: W] = 8'd3;
    wait_busy(1'b1, 50, "t6_grant");
    req_valid = '0;
    for (int n = 0; n < 4; n++) step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    spur = 1'b1;
    step();
    spur = 1'b0;
    for (int n = 0; n < 5; n++) step();
    req_valid = '1;
    wait_busy(1'b1, 50, "t6_regrant");
    chk("t6_first", (gq.size() > 0) ? gq[0] : -1, 0);
    req_valid = '0;
    rsp_ready = '1;
    wait_busy(1'b0, 200, "t6_drain");

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      req_valid = N'($urandom);
      req_sign  = N'($urandom);
      for (int i = 0; i < N; i++) begin
        req_dividend[i*W +: W] = W'($urandom);
        req_divisor[i*W +: W] =
          ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
        rsp_ready[i] = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    req_valid = '0;
    rsp_ready = '1;
    wait_busy(1'b0, 200, "rand_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
